data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the multicycle core's data-memory request interface: accepts one
//  read/write request at a time, performs the RV32I byte/half/word access on an internal word
//  array after a programmable wait time, and returns a one-cycle response.
//  Sits between the core datapath (MAR/MDR, mem_read/mem_write) and the data storage.
// PARAMETERS
//  DEPTH_LOG2   10  log2 of array depth in 32-bit words (1024 words = 4 KiB)
//  LATENCY      2   wait cycles between accept and response (0..15)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  req_read     in   1   load request (level, held until resp_valid)
//  req_write    in   1   store request (level, held until resp_valid)
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned (byte/half in low bits)
//  req_funct3   in   3   RV32I size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  busy         out  1   1 from accept cycle+1 until resp_valid cycle inclusive
//  resp_valid   out  1   one-cycle completion pulse
//  resp_err     out  1   qualified by resp_valid: misaligned/illegal request, no access done
//  resp_rdata   out  32  load data, extended per funct3; held until next response
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, busy=0, resp_valid=0, resp_err=0, resp_rdata=0,
//    wait counter=0. Array contents NOT reset. A write not yet committed is discarded.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE; IDLE -> ERR -> IDLE.
//    IDLE: if req_read|req_write, latch addr/wdata/funct3/kind; if illegal -> ERR, else
//          load counter=LATENCY and -> WAIT (LATENCY=0: -> RESP directly).
//    WAIT: decrement counter; at 1 -> RESP. Inputs ignored.
//    RESP: resp_valid=1, resp_err=0; store commits to array this cycle; load drives
//          resp_rdata from array. -> IDLE.
//    ERR:  resp_valid=1, resp_err=1, resp_rdata=0, array unchanged. -> IDLE.
//  - Latency: accept at edge N, resp_valid high during cycle N+1+LATENCY.
//  - Back-to-back: a request still asserted in the IDLE cycle after RESP is a NEW request;
//    core must drop the request in the cycle it samples resp_valid.
//  - Request deasserted while busy: operation still completes using latched values.
//  - Illegal: req_read&req_write both high; funct3 011/110/111; store funct3 100/101;
//    half with addr[0]=1; word with addr[1:0]!=0.
//  - Addressing: word index = req_addr[DEPTH_LOG2+1:2]; upper bits ignored (aliasing, no error).
//  - Stores: sb writes lane addr[1:0] with wdata[7:0]; sh writes lanes {addr[1],0}/+1 with
//    wdata[15:0]; sw writes all 4 lanes. Other lanes unchanged (per-byte enables).
//  - Loads: lb/lh sign-extend, lbu/lhu zero-extend selected lane(s); lw full word.
//  - Load of a word stored in the immediately preceding access returns the new data.
// STRUCTURE
//  - Shared header mem_defs.vh: funct3 size codes (MEM_B/H/W/BU/HU), FSM state encodings.
//  - Sub-module lsu_lane_align (combinational): byte enables + store-data replication from
//    funct3/addr[1:0]; load lane select + sign/zero extension. Instantiated once.
//  - Top holds FSM, wait counter, request latches, word array with byte enables.
// TESTING
//  1. sw 0xDEADBEEF @0x10, LATENCY=2 -> resp_valid at cycle accept+3, resp_err=0; lw @0x10
//     -> resp_rdata=0xDEADBEEF.
//  2. sb 0x80 @0x13 after (1); lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080;
//     lw @0x10 -> 0x80ADBEEF.
//  3. sh 0x8001 @0x22; lh @0x22 -> 0xFFFF8001; lhu -> 0x00008001; lh @0x21 -> resp_err=1,
//     rdata=0, array unchanged.
//  4. sw @0x06 and req_read&req_write together -> ERR response one cycle after accept,
//     resp_err=1; subsequent lw @0x04 returns prior contents.
//  5. Assert reset during WAIT of sw 0x12345678 @0x30 -> outputs 0 immediately, busy=0;
//     lw @0x30 afterward returns pre-reset value.
//  6. LATENCY=0, req_read held high for 3 accesses -> resp_valid every 2nd cycle, busy=1 in
//     RESP cycles only; addr 0x1000 aliases to 0x0 with DEPTH_LOG2=10.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access size codes, FSM states
// and the request legality check used at accept time.
package data_mem_responder_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic logic req_illegal(input logic rd, input logic wr,
                                         input logic [2:0] f3, input logic [1:0] lane);
        logic bad;
        bad = rd & wr;
        case (f3)
            MEM_B, MEM_BU: bad = bad;
            MEM_H, MEM_HU: bad = bad | lane[0];
            MEM_W:         bad = bad | (lane != 2'b00);
            default:       bad = 1'b1;
        endcase
        // Unsigned sizes only make sense for loads.
        if (wr && f3[2]) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_responder_lsu_lane_align.sv
// Byte-lane steering: store byte enables and data replication, load lane select with
// sign/zero extension.
module lsu_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be   = 4'b1111;
        st_data = st_wdata;
        case (st_funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << st_lane;
                st_data = {4{st_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = st_lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{st_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = st_wdata;
            end
        endcase
    end

    always_comb begin
        ld_shifted = ld_word >> {ld_lane, 3'b000};
        ld_byte    = ld_shifted[7:0];
        ld_half    = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            MEM_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_BU:  ld_data = {24'd0, ld_byte};
            MEM_H:   ld_data = {{16{ld_half[15]}}, ld_half};
            MEM_HU:  ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, programmable wait, one-cycle response,
// byte-enabled word array with registered read.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        busy,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata
);

    localparam int         AW    = DEPTH_LOG2 + 2;
    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_lane_q, ld_lane_d;
    logic              rzero_q, rzero_d;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           rd_word_q;
    logic                  rd_en;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [3:0]            st_be;
    logic [31:0]           st_data;
    logic [31:0]           ld_data;
    logic                  addr_hi_unused;

    // Upper address bits alias onto the array by design.
    assign addr_hi_unused = ^req_addr[31:AW];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        read_d    = read_q;
        write_d   = write_q;
        ld_f3_d   = ld_f3_q;
        ld_lane_d = ld_lane_q;
        rzero_d   = rzero_q;
        case (state_q)
            ST_IDLE: begin
                if (req_read || req_write) begin
                    addr_d   = req_addr[AW-1:0];
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    read_d   = req_read;
                    write_d  = req_write;
                    if (req_illegal(req_read, req_write, req_funct3, req_addr[1:0])) begin
                        state_d = ST_ERR;
                    end else if (LAT == 4'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = LAT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The array is read on the edge entering RESP so load data is valid during RESP.
        rd_en  = (state_d == ST_RESP) && (state_q != ST_RESP) &&
                 ((state_q == ST_IDLE) ? req_read : read_q);
        rd_idx = (state_q == ST_IDLE) ? req_addr[AW-1:2] : addr_q[AW-1:2];
        if (rd_en) begin
            ld_f3_d   = (state_q == ST_IDLE) ? req_funct3 : funct3_q;
            ld_lane_d = (state_q == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];
            rzero_d   = 1'b0;
        end
        if (state_d == ST_ERR) begin
            rzero_d = 1'b1;
        end

        wr_en   = (state_q == ST_RESP) && write_q;
        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_RESP) || (state_d == ST_ERR);
        err_d   = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            funct3_q  <= 3'd0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ld_f3_q   <= MEM_W;
            ld_lane_q <= 2'd0;
            rzero_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            funct3_q  <= funct3_d;
            read_q    <= read_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ld_f3_q   <= ld_f3_d;
            ld_lane_q <= ld_lane_d;
            rzero_q   <= rzero_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && st_be[b]) begin
                mem[addr_q[AW-1:2]][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
        if (rd_en) begin
            rd_word_q <= mem[rd_idx];
        end
    end

    lsu_lane_align u_align (
        .st_funct3 (funct3_q),
        .st_lane   (addr_q[1:0]),
        .st_wdata  (wdata_q),
        .st_be     (st_be),
        .st_data   (st_data),
        .ld_funct3 (ld_f3_q),
        .ld_lane   (ld_lane_q),
        .ld_word   (rd_word_q),
        .ld_data   (ld_data)
    );

    assign busy       = busy_q;
    assign resp_valid = valid_q;
    assign resp_err   = err_q;
    assign resp_rdata = rzero_q ? 32'd0 : ld_data;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 instance for data/size/error checks, LATENCY=0 instance for
// back-to-back and aliasing checks.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_rd, a_wr, a_busy, a_valid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [2:0]  a_f3;
    logic        b_rd, b_wr, b_busy, b_valid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [2:0]  b_f3;

    data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset), .req_read(a_rd), .req_write(a_wr), .req_addr(a_addr),
        .req_wdata(a_wdata), .req_funct3(a_f3), .busy(a_busy), .resp_valid(a_valid),
        .resp_err(a_err), .resp_rdata(a_rdata)
    );

    data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dut_b (
        .clk(clk), .reset(reset), .req_read(b_rd), .req_write(b_wr), .req_addr(b_addr),
        .req_wdata(b_wdata), .req_funct3(b_f3), .busy(b_busy), .resp_valid(b_valid),
        .resp_err(b_err), .resp_rdata(b_rdata)
    );

    typedef struct {
        bit          sel;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        err;
        bit          chk_rd;
        logic [31:0] rdata;
    } vec_t;

    vec_t tab1[$];
    vec_t tab2[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(bit sel, logic rd, logic wr, logic [31:0] addr,
                                logic [31:0] wdata, logic [2:0] f3, logic err,
                                bit chk_rd, logic [31:0] rdata);
        vec_t v;
        v.sel = sel; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.f3 = f3; v.err = err; v.chk_rd = chk_rd; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(bit sel, logic rd, logic wr, logic [31:0] addr,
                         logic [31:0] wdata, logic [2:0] f3);
        if (sel) begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata; b_f3 = f3;
        end else begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata; a_f3 = f3;
        end
    endtask

    task automatic transact(vec_t v);
        int   edges;
        int   exp_lat;
        bit   got;
        logic busy_s, valid_s, err_s;
        logic [31:0] rdata_s;
        exp_lat = v.err ? 1 : (v.sel ? 1 : 3);
        @(negedge clk);
        chk("idle_busy", {31'd0, v.sel ? b_busy : a_busy}, 32'd0);
        drive(v.sel, v.rd, v.wr, v.addr, v.wdata, v.f3);
        edges = 0;
        got = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            busy_s  = v.sel ? b_busy  : a_busy;
            valid_s = v.sel ? b_valid : a_valid;
            if (edges == 1) chk("busy_after_accept", {31'd0, busy_s}, 32'd1);
            if (valid_s) got = 1'b1;
        end
        err_s   = v.sel ? b_err   : a_err;
        rdata_s = v.sel ? b_rdata : a_rdata;
        drive(v.sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        if (!got) begin
            chk("resp_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", edges, exp_lat);
            chk("resp_err", {31'd0, err_s}, {31'd0, v.err});
            if (v.chk_rd) chk("resp_rdata", rdata_s, v.rdata);
        end
        $display("txn dut%0d rd=%0b wr=%0b addr=%h wdata=%h f3=%0d -> lat=%0d err=%0b rdata=%h",
                 v.sel, v.rd, v.wr, v.addr, v.wdata, v.f3, edges, err_s, rdata_s);
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);

        tab1.push_back(mk(0, 1, 0, 32'h10, 0, 3'd2, 0, 0, 0));  // pre-touch, no data check
        tab1.push_back(mk(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'd2, 0, 0, 0));
        tab1.push_back(mk(0, 1, 0, 32'h10, 0, 3'd2, 0, 1, 32'hDEADBEEF));
        tab1.push_back(mk(0, 0, 1, 32'h13, 32'h80, 3'd0, 0, 0, 0));
        tab1.push_back(mk(0, 1, 0, 32'h13, 0, 3'd0, 0, 1, 32'hFFFFFF80));
        tab1.push_back(mk(0, 1, 0, 32'h13, 0, 3'd4, 0, 1, 32'h00000080));
        tab1.push_back(mk(0, 1, 0, 32'h10, 0, 3'd2, 0, 1, 32'h80ADBEEF));
        tab1.push_back(mk(0, 0, 1, 32'h1011, 32'h55, 3'd0, 0, 0, 0));
        tab1.push_back(mk(0, 1, 0, 32'h10, 0, 3'd2, 0, 1, 32'h80AD55EF));
        tab1.push_back(mk(0, 0, 1, 32'h20, 32'h0, 3'd2, 0, 0, 0));
        tab1.push_back(mk(0, 0, 1, 32'h22, 32'h8001, 3'd1, 0, 0, 0));
        tab1.push_back(mk(0, 1, 0, 32'h22, 0, 3'd1, 0, 1, 32'hFFFF8001));
        tab1.push_back(mk(0, 1, 0, 32'h22, 0, 3'd5, 0, 1, 32'h00008001));
        tab1.push_back(mk(0, 1, 0, 32'h21, 0, 3'd1, 1, 1, 32'h0));
        tab1.push_back(mk(0, 1, 0, 32'h20, 0, 3'd2, 0, 1, 32'h80010000));
        tab1.push_back(mk(0, 1, 0, 32'h23, 0, 3'd0, 0, 1, 32'hFFFFFF80));
        tab1.push_back(mk(0, 1, 0, 32'h22, 0, 3'd4, 0, 1, 32'h00000001));
        tab1.push_back(mk(0, 0, 1, 32'h04, 32'h11223344, 3'd2, 0, 0, 0));
        tab1.push_back(mk(0, 0, 1, 32'h06, 32'h99999999, 3'd2, 1, 1, 32'h0));
        tab1.push_back(mk(0, 1, 1, 32'h04, 32'h77777777, 3'd2, 1, 1, 32'h0));
        tab1.push_back(mk(0, 1, 0, 32'h04, 0, 3'd2, 0, 1, 32'h11223344));
        tab1.push_back(mk(0, 1, 0, 32'h04, 0, 3'd3, 1, 1, 32'h0));
        tab1.push_back(mk(0, 0, 1, 32'h04, 32'hAA, 3'd4, 1, 1, 32'h0));
        tab1.push_back(mk(0, 1, 0, 32'h04, 0, 3'd2, 0, 1, 32'h11223344));
        tab1.push_back(mk(0, 0, 1, 32'h30, 32'hCAFEF00D, 3'd2, 0, 0, 0));
        tab1.push_back(mk(0, 1, 0, 32'h30, 0, 3'd2, 0, 1, 32'hCAFEF00D));

        tab2.push_back(mk(0, 1, 0, 32'h30, 0, 3'd2, 0, 1, 32'hCAFEF00D));
        tab2.push_back(mk(1, 0, 1, 32'h1000, 32'hA5A5A5A5, 3'd2, 0, 0, 0));
        tab2.push_back(mk(1, 1, 0, 32'h0, 0, 3'd2, 0, 1, 32'hA5A5A5A5));
        tab2.push_back(mk(1, 0, 1, 32'h1002, 32'h7FFE, 3'd1, 0, 0, 0));
        tab2.push_back(mk(1, 1, 0, 32'h2, 0, 3'd1, 0, 1, 32'h00007FFE));
        tab2.push_back(mk(1, 1, 0, 32'h1000, 0, 3'd2, 0, 1, 32'h7FFEA5A5));

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy_a",  {31'd0, a_busy},  32'd0);
        chk("rst_valid_a", {31'd0, a_valid}, 32'd0);
        chk("rst_err_a",   {31'd0, a_err},   32'd0);
        chk("rst_rdata_a", a_rdata, 32'd0);
        chk("rst_busy_b",  {31'd0, b_busy},  32'd0);
        chk("rst_valid_b", {31'd0, b_valid}, 32'd0);
        chk("rst_rdata_b", b_rdata, 32'd0);

        foreach (tab1[i]) transact(tab1[i]);

        // Reset during WAIT discards the pending store and clears outputs at once.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h12345678, 3'd2);
        @(posedge clk);
        #1;
        chk("wait_busy", {31'd0, a_busy}, 32'd1);
        chk("wait_valid", {31'd0, a_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_rst_busy",  {31'd0, a_busy},  32'd0);
        chk("async_rst_valid", {31'd0, a_valid}, 32'd0);
        chk("async_rst_err",   {31'd0, a_err},   32'd0);
        chk("async_rst_rdata", a_rdata, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("txn dut0 reset asserted during WAIT of sw 12345678 @30");

        foreach (tab2[i]) transact(tab2[i]);

        // LATENCY=0 with the load held: a response on every second cycle.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 3'd2);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            chk("held_valid", {31'd0, b_valid}, {31'd0, e[0]});
            chk("held_busy",  {31'd0, b_busy},  {31'd0, e[0]});
            if (e[0]) chk("held_rdata", b_rdata, 32'h7FFEA5A5);
            $display("txn dut1 held lw @0 cycle %0d -> valid=%0b busy=%0b rdata=%h",
                     e, b_valid, b_busy, b_rdata);
            if (e == 5) drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
